// File: rtl/mul_issue_sched_pkg.sv
// rtl/mul_issue_sched_pkg.sv - shared types for the multiplier issue scheduler
//
// Purpose: requester id, scheduler state and pipeline tag types, plus the
//          round-robin pick helper used by the arbiter.
// Ports:   none (package).
package mul_sched_pkg;

  typedef logic req_id_t;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    DONE  = 2'd2
  } sched_state_t;

  typedef struct packed {
    logic    vld;
    req_id_t id;
  } mul_tag_t;

  localparam int unsigned NUM_REQ = 2;

  // With both requesters pending the pointer decides; otherwise the single
  // pending requester wins. With nothing pending the result is 0 and unused.
  function automatic req_id_t rr_pick(input logic [NUM_REQ-1:0] valid,
                                      input req_id_t ptr);
    req_id_t pick;
    if (valid == 2'b11) begin
      pick = ptr;
    end else if (valid[1]) begin
      pick = 1'b1;
    end else begin
      pick = 1'b0;
    end
    return pick;
  endfunction

endpackage

// File: rtl/mul_issue_sched_if.sv
// rtl/mul_issue_sched_if.sv - issue/result/drain bundle for the scheduler
//
// Purpose: groups the requester handshake, multiplier control, result tag
//          and drain handshake of mul_issue_sched.
// Signals:
//   req_valid[1:0]  requester -> sched   issue request per requester
//   req_ready[1:0]  sched -> requester   one-hot grant
//   mul_start       sched -> datapath    operand capture strobe
//   mul_sel         sched -> datapath    operand mux select (granted id)
//   res_valid       sched -> consumer    result valid at pipeline output
//   res_id          sched -> consumer    owner of current result
//   inflight        sched -> control     issued but not yet retired
//   drain_req       control -> sched     stop issuing and empty pipeline
//   drain_done      sched -> control     pipeline empty, issue stopped
// Modports: master = requesters/control side, slave = scheduler side.
interface mul_issue_sched_if #(
  parameter int LATENCY = 4
);
  import mul_sched_pkg::*;

  localparam int CNT_W = $clog2(LATENCY + 1);

  logic [NUM_REQ-1:0] req_valid;
  logic [NUM_REQ-1:0] req_ready;
  logic               mul_start;
  req_id_t            mul_sel;
  logic               res_valid;
  req_id_t            res_id;
  logic [CNT_W-1:0]   inflight;
  logic               drain_req;
  logic               drain_done;

  modport master (
    output req_valid,
    output drain_req,
    input  req_ready,
    input  mul_start,
    input  mul_sel,
    input  res_valid,
    input  res_id,
    input  inflight,
    input  drain_done
  );

  modport slave (
    input  req_valid,
    input  drain_req,
    output req_ready,
    output mul_start,
    output mul_sel,
    output res_valid,
    output res_id,
    output inflight,
    output drain_done
  );

endinterface

// File: rtl/mul_issue_sched_tag_delay.sv
// rtl/mul_issue_sched_tag_delay.sv - fixed-depth tag register chain
//
// Purpose: delays a WIDTH-bit tag by exactly DELAY clock cycles, mirroring
//          the multiplier datapath latency. Async active-low clear empties
//          every stage so no stale tag survives a reset.
// Ports:
//   clk   in   1      rising-edge clock
//   rst   in   1      asynchronous, active-low clear
//   din   in   WIDTH  tag entering the chain
//   dout  out  WIDTH  tag leaving the chain DELAY cycles later
module tag_delay #(
  parameter int WIDTH = 2,
  parameter int DELAY = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] stage_q [DELAY];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < DELAY; k++) begin
        stage_q[k] <= '0;
      end
    end else begin
      stage_q[0] <= din;
      for (int k = 1; k < DELAY; k++) begin
        stage_q[k] <= stage_q[k-1];
      end
    end
  end

  assign dout = stage_q[DELAY-1];

endmodule

// File: rtl/mul_issue_sched.sv
// rtl/mul_issue_sched.sv - round-robin issue scheduler for the multiplier pipeline
//
// Purpose: shares one LATENCY-deep multiplier between two requesters, issuing
//          at most one operation per cycle, tagging each issue with its owner
//          so results come back labelled, and offering a drain handshake so
//          control can quiesce the pipeline before mode changes.
// Ports:
//   clk   in   1   rising-edge clock
//   rst   in   1   asynchronous, active-low reset
//   bus   slave    mul_issue_sched_if (requests, grants, multiplier control,
//                  result tag, in-flight count, drain handshake)
module mul_issue_sched
  import mul_sched_pkg::*;
#(
  parameter int LATENCY = 4
) (
  input  logic             clk,
  input  logic             rst,
  mul_issue_sched_if.slave bus
);

  localparam int CNT_W = $clog2(LATENCY + 1);

  sched_state_t       state_q, state_d;
  req_id_t            rr_ptr_q;
  logic [CNT_W-1:0]   inflight_q, inflight_d;

  logic               grant_en;
  req_id_t            gnt_id;
  logic [NUM_REQ-1:0] ready;
  logic               start;
  req_id_t            sel;
  mul_tag_t           tag_in, tag_out;
  logic               retire;

  // Grant only from RUN with no drain pending; the result path never feeds
  // back into the grant, so a requester can never stall on its own result.
  always_comb begin
    grant_en = (state_q == RUN) && !bus.drain_req && (|bus.req_valid);
    gnt_id   = rr_pick(bus.req_valid, rr_ptr_q);
    ready    = '0;
    if (grant_en) begin
      ready[gnt_id] = 1'b1;
    end
    start = |(bus.req_valid & ready);
    sel   = start ? gnt_id : 1'b0;
  end

  assign bus.req_ready = ready;
  assign bus.mul_start = start;
  assign bus.mul_sel   = sel;

  // Tag travels beside the operands; the chain depth equals the datapath
  // latency so the tag and the product leave together.
  always_comb begin
    tag_in     = '0;
    tag_in.vld = start;
    tag_in.id  = sel;
  end

  tag_delay #(
    .WIDTH ($bits(mul_tag_t)),
    .DELAY (LATENCY)
  ) u_tag_delay (
    .clk  (clk),
    .rst  (rst),
    .din  (tag_in),
    .dout (tag_out)
  );

  assign retire        = tag_out.vld;
  assign bus.res_valid = retire;
  assign bus.res_id    = retire ? tag_out.id : 1'b0;

  // One issue per cycle bounds the count by LATENCY, so no saturation.
  always_comb begin
    inflight_d = inflight_q + CNT_W'(start) - CNT_W'(retire);
  end

  assign bus.inflight = inflight_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN: begin
        if (bus.drain_req) begin
          state_d = (inflight_q == '0) ? DONE : DRAIN;
        end
      end
      // Once draining, finish emptying even if drain_req drops; control then
      // sees one DONE cycle before issue resumes.
      DRAIN: begin
        if (inflight_d == '0) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (!bus.drain_req) begin
          state_d = RUN;
        end
      end
      default: state_d = RUN;
    endcase
  end

  assign bus.drain_done = (state_q == DONE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= RUN;
      rr_ptr_q   <= 1'b0;
      inflight_q <= '0;
    end else begin
      state_q    <= state_d;
      inflight_q <= inflight_d;
      if (start) begin
        rr_ptr_q <= ~gnt_id;
      end
    end
  end

endmodule
